trace_capture: RTL and testbench
================================

Name: trace_capture

Overview:
- Parametrised in-fabric trace capture for on-board debug. Generalises the fixed ILA probe bus, the half-rate clock toggle and the VIO-driven reset into one block.
- Block contents: configurable-width probe bus; sample-enable divider; mask/value trigger with level and edge modes; pre-trigger ring buffer; random-access readout port.
- Sits beside cache_top. Probes CPU/SDRAM/FSM signals; results are read back through a VIO or LED mux.

Parameters:
- DATA_W, 64, probe/sample width in bits.
- DEPTH, 256, buffer depth in samples; power of 2, >= 2.
- ADDR_W, log2(DEPTH), derived; not overridden.
- PRE_TRIG, 64, samples kept before the trigger sample; 0 <= PRE_TRIG <= DEPTH-1.
- CLK_DIV, 2, one sample every CLK_DIV clk cycles; >= 1.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- arm  in  1  one-cycle pulse that starts or restarts a capture.
- probe  in  DATA_W  signals under observation.
- trig_mask  in  DATA_W  1 = bit participates in the match.
- trig_value  in  DATA_W  compare value.
- trig_mode  in  1  0 = level match, 1 = rising edge of match.
- rd_addr  in  ADDR_W  logical read index; 0 = oldest captured sample.
- rd_data  out  DATA_W  sample at rd_addr; registered.
- sample_en  out  1  divider strobe.
- state  out  3  FSM state code.
- triggered  out  1  trigger seen in the current capture.
- done  out  1  capture complete; buffer valid.
- trig_ptr  out  ADDR_W  physical address of the trigger sample.

Behaviour:
- Reset (rst=0, async): every register returns to zero.
  - state=IDLE(0); div counter=0; wr_ptr=0; pre/post counters=0; match_prev=0.
  - Outputs: sample_en=0, triggered=0, done=0, trig_ptr=0, rd_data=0.
  - A reset during any capture aborts it; memory contents are don't-care.
- Divider: free-running counter 0..CLK_DIV-1. sample_en=1 in the cycle where count==CLK_DIV-1. With CLK_DIV=1, sample_en is constantly 1 after reset. arm does not reset the divider.
- Match: match = (((probe ^ trig_value) & trig_mask) == 0). All-zero mask matches every sample.
  - Level mode: hit = match.
  - Edge mode: hit = match & ~match_prev.
  - match_prev is cleared on arm and updated with match on every sample in PRE/WAIT.
- Sample: a clk edge with sample_en=1 while state is PRE, WAIT or POST. The sample writes probe to mem[wr_ptr], then wr_ptr increments mod DEPTH.
- FSM (codes IDLE=0, PRE=1, WAIT=2, POST=3, DONE=4):
  - IDLE: on arm -> PRE.
  - PRE: pre_cnt counts samples; hit is ignored. After the PRE_TRIG-th sample -> WAIT. If PRE_TRIG=0, arm goes directly to WAIT.
  - WAIT: ring wraps freely. On a sample with hit: write it, trig_ptr <= wr_ptr, triggered <= 1, then -> POST. If DEPTH-1-PRE_TRIG == 0, go -> DONE instead.
  - POST: exactly DEPTH-1-PRE_TRIG further samples, then -> DONE.
  - DONE: done=1, no writes. Holds until arm -> PRE.
- arm handling:
  - On arm in any state (IDLE/PRE/WAIT/POST/DONE), the next cycle has: state=PRE (or WAIT if PRE_TRIG=0), wr_ptr=0, counters=0, triggered=0, done=0, match_prev=0.
  - arm coinciding with a sample strobe: arm wins; that sample is not written.
- Readout:
  - phys = (trig_ptr - PRE_TRIG + rd_addr) mod DEPTH.
  - rd_data is valid one clk after rd_addr.
  - Reads are legal in any state; data is meaningful only when done=1.
- Memory is a single-write, single-read synchronous array, inferable as block RAM.

Test Plan:
Bench settings: DATA_W=8, DEPTH=16, PRE_TRIG=4, CLK_DIV=1, trig_mask=0xFF, probe = sample index k (mod 256) starting at the first sample after arm.
1. Level trigger: trig_value=0x0A, mode 0, arm.
   -> PRE samples 0-3, trigger on sample 10, trig_ptr=10, POST samples 11-21, done=1.
   -> rd_addr 0/4/15 returns 0x06/0x0A/0x15 one cycle later.
2. Trigger value inside the pre-trigger window: trig_value=0x02.
   -> ignored in PRE; triggers at k=258.
   -> rd_addr 0/4/15 returns 0xFE/0x02/0x0D.
3. Constant probe=0x55, trig_value=0x55.
   -> mode 0: triggers on sample 4, trig_ptr=4.
   -> mode 1: state stays WAIT (2) for 100 samples, triggered=0.
4. CLK_DIV=3, trig_mask=0x00.
   -> sample_en every 3rd cycle; trigger on sample 4; done after 16 samples (about 48 cycles from arm).
   -> No write occurs on non-strobe cycles.
5. arm mid-POST, then rst=0 mid-WAIT.
   -> re-arm: next cycle state=1, triggered=0, done=0, capture restarts at wr_ptr=0.
   -> async reset: immediately state=0 and all outputs 0.
6. PRE_TRIG=15, trig_value=0x20.
   -> trigger on sample 32 goes straight to DONE.
   -> rd_addr 0 = 0x11, rd_addr 15 = 0x20.

Source files
------------

// File: rtl/trace_capture.sv
// trace_capture: in-fabric trace capture for on-board debug.
//
// A free-running divider produces a sample strobe. While a capture runs,
// each strobe writes the probe bus into a ring buffer. A mask/value
// trigger, in level or rising-edge mode, marks the trigger sample. The
// buffer keeps PRE_TRIG samples before that sample and DEPTH-1-PRE_TRIG
// samples after it. When the capture completes, the buffer is read back
// by logical index, where index 0 is the oldest sample.
//
// Ports
//   clk        : clock; all logic runs on posedge
//   rst        : asynchronous, active-low reset
//   arm        : one-cycle pulse that starts or restarts a capture
//   probe      : signals under observation (DATA_W)
//   trig_mask  : 1 = bit takes part in the trigger match
//   trig_value : trigger compare value
//   trig_mode  : 0 = level match, 1 = rising edge of match
//   rd_addr    : logical read index; 0 = oldest captured sample
//   rd_data    : sample at rd_addr, registered (valid one clk later)
//   sample_en  : divider strobe
//   state      : FSM state code (IDLE=0 PRE=1 WAIT=2 POST=3 DONE=4)
//   triggered  : trigger seen in the current capture
//   done       : capture complete; buffer contents valid
//   trig_ptr   : physical buffer address of the trigger sample
//
// Control protocol: there is no valid/ready handshake. arm is a single-cycle
// command that is accepted in every state. done stays high until the next
// arm. Reads are accepted in any state, but the data is meaningful only
// while done=1.
module trace_capture #(
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 256,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int PRE_TRIG = 64,
  parameter int CLK_DIV  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic [DATA_W-1:0] probe,
  input  logic [DATA_W-1:0] trig_mask,
  input  logic [DATA_W-1:0] trig_value,
  input  logic              trig_mode,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              sample_en,
  output logic [2:0]        state,
  output logic              triggered,
  output logic              done,
  output logic [ADDR_W-1:0] trig_ptr
);

  localparam int POST_N = DEPTH - 1 - PRE_TRIG;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'((PRE_TRIG > 0) ? PRE_TRIG - 1 : 0);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'((POST_N > 0) ? POST_N - 1 : 0);
  localparam logic [ADDR_W-1:0] PRE_OFF   = ADDR_W'(PRE_TRIG);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [DIV_W-1:0]  div_cnt;
  logic [DIV_W-1:0]  div_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] cnt_q;      // pre-trigger count in PRE, post-trigger count in POST
  logic              match_prev;
  logic              match;
  logic              hit;
  logic              do_sample;
  logic              trig_fire;
  logic [ADDR_W-1:0] rd_phys;

  logic [DATA_W-1:0] mem [DEPTH];

  // Divider: the strobe is registered so that it reads 0 during reset. It
  // is high in exactly the cycles where div_cnt == CLK_DIV-1.
  always_comb begin
    div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
  end

  // Trigger match and sample qualification. arm takes priority over a
  // coincident strobe, so that sample is dropped.
  always_comb begin
    match     = (((probe ^ trig_value) & trig_mask) == '0);
    hit       = trig_mode ? (match & ~match_prev) : match;
    do_sample = sample_en & ~arm &
                ((state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST));
    trig_fire = do_sample & (state_q == S_WAIT) & hit;
    rd_phys   = trig_ptr - PRE_OFF + rd_addr;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (arm) begin
      state_d = (PRE_TRIG == 0) ? S_WAIT : S_PRE;
    end else if (do_sample) begin
      case (state_q)
        S_PRE:   if (cnt_q == PRE_LAST) state_d = S_WAIT;
        S_WAIT:  if (hit) state_d = (POST_N == 0) ? S_DONE : S_POST;
        S_POST:  if (cnt_q == POST_LAST) state_d = S_DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt    <= '0;
      sample_en  <= 1'b0;
      wr_ptr     <= '0;
      cnt_q      <= '0;
      match_prev <= 1'b0;
      triggered  <= 1'b0;
      trig_ptr   <= '0;
      rd_data    <= '0;
    end else begin
      div_cnt   <= div_nxt;
      sample_en <= (div_nxt == DIV_LAST);
      rd_data   <= mem[rd_phys];
      if (arm) begin
        wr_ptr     <= '0;
        cnt_q      <= '0;
        match_prev <= 1'b0;
        triggered  <= 1'b0;
      end else if (do_sample) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
        if ((state_q == S_PRE) || (state_q == S_WAIT)) match_prev <= match;
        // The counter restarts on every state change, so PRE and POST
        // each count from zero.
        if (state_d != state_q) cnt_q <= '0;
        else                    cnt_q <= cnt_q + ADDR_W'(1);
        if (trig_fire) begin
          trig_ptr  <= wr_ptr;
          triggered <= 1'b1;
        end
      end
    end
  end

  // Buffer write port. There is no reset, so the array can map onto block RAM.
  always_ff @(posedge clk) begin
    if (do_sample) mem[wr_ptr] <= probe;
  end

  assign state = state_q;
  assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture. It uses three instances with DATA_W=8 and
// DEPTH=16:
//   dut_a : PRE_TRIG=4,  CLK_DIV=1
//   dut_b : PRE_TRIG=4,  CLK_DIV=3
//   dut_c : PRE_TRIG=15, CLK_DIV=1
// The probe carries the sample index k, which starts at 0 on the first
// sample after arm.
module tb_trace_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic       arm_a, arm_b, arm_c;
  logic [7:0] probe, trig_mask, trig_value;
  logic       trig_mode;
  logic [3:0] rd_addr;

  logic [7:0] rd_data_a, rd_data_b, rd_data_c;
  logic       sample_en_a, sample_en_b, sample_en_c;
  logic [2:0] state_a, state_b, state_c;
  logic       triggered_a, triggered_b, triggered_c;
  logic       done_a, done_b, done_c;
  logic [3:0] trig_ptr_a, trig_ptr_b, trig_ptr_c;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  trace_capture #(.DATA_W(8), .DEPTH(16), .PRE_TRIG(4), .CLK_DIV(1)) dut_a (
    .clk(clk), .rst(rst), .arm(arm_a), .probe(probe), .trig_mask(trig_mask),
    .trig_value(trig_value), .trig_mode(trig_mode), .rd_addr(rd_addr),
    .rd_data(rd_data_a), .sample_en(sample_en_a), .state(state_a),
    .triggered(triggered_a), .done(done_a), .trig_ptr(trig_ptr_a));

  trace_capture #(.DATA_W(8), .DEPTH(16), .PRE_TRIG(4), .CLK_DIV(3)) dut_b (
    .clk(clk), .rst(rst), .arm(arm_b), .probe(probe), .trig_mask(trig_mask),
    .trig_value(trig_value), .trig_mode(trig_mode), .rd_addr(rd_addr),
    .rd_data(rd_data_b), .sample_en(sample_en_b), .state(state_b),
    .triggered(triggered_b), .done(done_b), .trig_ptr(trig_ptr_b));

  trace_capture #(.DATA_W(8), .DEPTH(16), .PRE_TRIG(15), .CLK_DIV(1)) dut_c (
    .clk(clk), .rst(rst), .arm(arm_c), .probe(probe), .trig_mask(trig_mask),
    .trig_value(trig_value), .trig_mode(trig_mode), .rd_addr(rd_addr),
    .rd_data(rd_data_c), .sample_en(sample_en_c), .state(state_c),
    .triggered(triggered_c), .done(done_c), .trig_ptr(trig_ptr_c));

  // ---------------- driver tasks ----------------
  task automatic pulse_arm(input int which);
    if (which == 0) arm_a = 1'b1;
    else if (which == 1) arm_b = 1'b1;
    else arm_c = 1'b1;
    @(posedge clk); #1;
    arm_a = 1'b0; arm_b = 1'b0; arm_c = 1'b0;
  endtask

  // Drives probe = k on consecutive samples (CLK_DIV=1 instances) until done
  // or max_samples. Returns the number of samples driven.
  task automatic run_counting(input int which, input int max_samples, output int k);
    k = 0;
    while (((which == 0) ? done_a : done_c) !== 1'b1 && k < max_samples) begin
      probe = 8'(k);
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic read_buf(input int which, input logic [3:0] a, output logic [7:0] d);
    rd_addr = a;
    @(posedge clk); #1;
    d = (which == 0) ? rd_data_a : (which == 1) ? rd_data_b : rd_data_c;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; arm_a = 0; arm_b = 0; arm_c = 0;
    probe = 8'h00; trig_mask = 8'hFF; trig_value = 8'h00; trig_mode = 1'b0; rd_addr = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (state_a !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_a); end
    checks++; if (sample_en_a !== 1'b0) begin errors++; $display("FAIL reset_sample_en got %b exp 0", sample_en_a); end
    checks++; if ({triggered_a, done_a} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {triggered_a, done_a}); end
    checks++; if (trig_ptr_a !== 4'd0) begin errors++; $display("FAIL reset_trig_ptr got %0d exp 0", trig_ptr_a); end
    checks++; if (rd_data_a !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h exp 00", rd_data_a); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (sample_en_a !== 1'b1) begin errors++; $display("FAIL div1_sample_en got %b exp 1", sample_en_a); end
    checks++; if (state_a !== 3'd0) begin errors++; $display("FAIL idle_no_arm got %0d exp 0", state_a); end
  endtask

  task automatic test_level_trigger();
    int k;
    logic [7:0] d;
    trig_mask = 8'hFF; trig_value = 8'h0A; trig_mode = 1'b0;
    pulse_arm(0);
    checks++; if (state_a !== 3'd1) begin errors++; $display("FAIL lvl_arm_state got %0d exp 1", state_a); end
    run_counting(0, 100, k);
    checks++; if (k !== 22) begin errors++; $display("FAIL lvl_sample_count got %0d exp 22", k); end
    checks++; if (state_a !== 3'd4 || done_a !== 1'b1) begin errors++; $display("FAIL lvl_done got state %0d done %b exp 4 1", state_a, done_a); end
    checks++; if (trig_ptr_a !== 4'd10) begin errors++; $display("FAIL lvl_trig_ptr got %0d exp 10", trig_ptr_a); end
    checks++; if (triggered_a !== 1'b1) begin errors++; $display("FAIL lvl_triggered got %b exp 1", triggered_a); end
    // The probe keeps moving while in DONE. Nothing must be written.
    for (int i = 0; i < 5; i++) begin probe = 8'hC0 + 8'(i); @(posedge clk); end
    #1;
    read_buf(0, 4'd0, d);
    checks++; if (d !== 8'h06) begin errors++; $display("FAIL lvl_rd0 got %h exp 06", d); end
    read_buf(0, 4'd4, d);
    checks++; if (d !== 8'h0A) begin errors++; $display("FAIL lvl_rd4 got %h exp 0a", d); end
    read_buf(0, 4'd15, d);
    checks++; if (d !== 8'h15) begin errors++; $display("FAIL lvl_rd15 got %h exp 15", d); end
  endtask

  task automatic test_pre_window();
    int k;
    logic [7:0] d;
    trig_value = 8'h02; trig_mode = 1'b0;
    pulse_arm(0);
    run_counting(0, 400, k);
    checks++; if (k !== 270) begin errors++; $display("FAIL prewin_sample_count got %0d exp 270", k); end
    checks++; if (trig_ptr_a !== 4'd2) begin errors++; $display("FAIL prewin_trig_ptr got %0d exp 2", trig_ptr_a); end
    read_buf(0, 4'd0, d);
    checks++; if (d !== 8'hFE) begin errors++; $display("FAIL prewin_rd0 got %h exp fe", d); end
    read_buf(0, 4'd4, d);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL prewin_rd4 got %h exp 02", d); end
    read_buf(0, 4'd15, d);
    checks++; if (d !== 8'h0D) begin errors++; $display("FAIL prewin_rd15 got %h exp 0d", d); end
  endtask

  task automatic test_const_probe();
    int n;
    probe = 8'h55; trig_value = 8'h55; trig_mode = 1'b0;
    pulse_arm(0);
    n = 0;
    while (done_a !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    checks++; if (done_a !== 1'b1 || trig_ptr_a !== 4'd4) begin errors++; $display("FAIL const_level got done %b trig_ptr %0d exp 1 4", done_a, trig_ptr_a); end
    trig_mode = 1'b1;
    pulse_arm(0);
    repeat (104) @(posedge clk);
    #1;
    checks++; if (state_a !== 3'd2) begin errors++; $display("FAIL const_edge_state got %0d exp 2", state_a); end
    checks++; if (triggered_a !== 1'b0) begin errors++; $display("FAIL const_edge_triggered got %b exp 0", triggered_a); end
  endtask

  task automatic test_clk_div3();
    int k, cyc, last_strobe, gap_err;
    logic [7:0] d;
    trig_mask = 8'h00; trig_value = 8'h00; trig_mode = 1'b0;
    pulse_arm(1);
    k = 0; cyc = 0; last_strobe = -1; gap_err = 0;
    while (done_b !== 1'b1 && cyc < 80) begin
      if (sample_en_b === 1'b1) begin
        probe = 8'(k); k++;
        if (last_strobe >= 0 && cyc - last_strobe != 3) gap_err++;
        last_strobe = cyc;
      end else begin
        probe = 8'hEE;
      end
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (k !== 16) begin errors++; $display("FAIL div3_samples got %0d exp 16", k); end
    checks++; if (gap_err !== 0) begin errors++; $display("FAIL div3_strobe_gap got %0d bad gaps exp 0", gap_err); end
    checks++; if (cyc < 46 || cyc > 48) begin errors++; $display("FAIL div3_done_latency got %0d exp 46..48", cyc); end
    checks++; if (trig_ptr_b !== 4'd4 || done_b !== 1'b1) begin errors++; $display("FAIL div3_trig got ptr %0d done %b exp 4 1", trig_ptr_b, done_b); end
    for (int i = 0; i < 16; i++) begin
      read_buf(1, 4'(i), d);
      checks++; if (d !== 8'(i)) begin errors++; $display("FAIL div3_rd%0d got %h exp %h", i, d, 8'(i)); end
    end
  endtask

  task automatic test_rearm_and_reset();
    int k;
    logic [7:0] d;
    trig_mask = 8'hFF; trig_value = 8'h0A; trig_mode = 1'b0;
    pulse_arm(0);
    k = 0;
    while (state_a !== 3'd3 && k < 40) begin probe = 8'(k); @(posedge clk); #1; k++; end
    checks++; if (state_a !== 3'd3) begin errors++; $display("FAIL rearm_reach_post got %0d exp 3", state_a); end
    probe = 8'hAA;
    pulse_arm(0);
    checks++; if (state_a !== 3'd1 || triggered_a !== 1'b0 || done_a !== 1'b0) begin
      errors++; $display("FAIL rearm_clear got state %0d trig %b done %b exp 1 0 0", state_a, triggered_a, done_a);
    end
    run_counting(0, 100, k);
    checks++; if (k !== 22 || trig_ptr_a !== 4'd10) begin errors++; $display("FAIL rearm_restart got k %0d ptr %0d exp 22 10", k, trig_ptr_a); end
    read_buf(0, 4'd0, d);
    checks++; if (d !== 8'h06) begin errors++; $display("FAIL rearm_rd0 got %h exp 06", d); end
    read_buf(0, 4'd4, d);
    pulse_arm(0);
    k = 0;
    while (state_a !== 3'd2 && k < 20) begin probe = 8'(k); @(posedge clk); #1; k++; end
    checks++; if (state_a !== 3'd2 || rd_data_a !== 8'h0A || trig_ptr_a !== 4'd10) begin
      errors++; $display("FAIL pre_reset_setup got state %0d rd %h ptr %0d exp 2 0a 10", state_a, rd_data_a, trig_ptr_a);
    end
    #2 rst = 1'b0;
    #1;
    checks++; if (state_a !== 3'd0 || sample_en_a !== 1'b0 || triggered_a !== 1'b0 || done_a !== 1'b0) begin
      errors++; $display("FAIL async_reset_ctrl got state %0d se %b trig %b done %b exp 0 0 0 0", state_a, sample_en_a, triggered_a, done_a);
    end
    checks++; if (trig_ptr_a !== 4'd0 || rd_data_a !== 8'h00) begin
      errors++; $display("FAIL async_reset_data got ptr %0d rd %h exp 0 00", trig_ptr_a, rd_data_a);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_pretrig_15();
    int k;
    logic [7:0] d;
    trig_mask = 8'hFF; trig_value = 8'h20; trig_mode = 1'b0;
    pulse_arm(2);
    run_counting(2, 80, k);
    checks++; if (k !== 33 || state_c !== 3'd4) begin errors++; $display("FAIL pt15_done got k %0d state %0d exp 33 4", k, state_c); end
    checks++; if (trig_ptr_c !== 4'd0 || triggered_c !== 1'b1) begin errors++; $display("FAIL pt15_trig got ptr %0d trig %b exp 0 1", trig_ptr_c, triggered_c); end
    read_buf(2, 4'd0, d);
    checks++; if (d !== 8'h11) begin errors++; $display("FAIL pt15_rd0 got %h exp 11", d); end
    read_buf(2, 4'd15, d);
    checks++; if (d !== 8'h20) begin errors++; $display("FAIL pt15_rd15 got %h exp 20", d); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_level_trigger();
    test_pre_window();
    test_const_probe();
    test_clk_div3();
    test_rearm_and_reset();
    test_pretrig_15();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
